// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: EX-stage to HI/LO multiply/divide unit handshake bundle
// master (EX stage) drives op_valid/op/operands/hi_cur/lo_cur/flush; slave (muldiv_seq) returns stall_o/hilowe/hi_o/lo_o/busy
interface muldiv_seq_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic [31:0] hi_cur;
    logic [31:0] lo_cur;
    logic        flush;
    logic        stall_o;
    logic        hilowe;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy;
    modport master (
        output op_valid, op, rs_i, rt_i, hi_cur, lo_cur, flush,
        input  stall_o, hilowe, hi_o, lo_o, busy
    );
    modport slave (
        input  op_valid, op, rs_i, rt_i, hi_cur, lo_cur, flush,
        output stall_o, hilowe, hi_o, lo_o, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit writing HI/LO
// ports: cpu_clk_50M clock, cpu_rst_n sync active-low reset, bus = muldiv_seq_if.slave (op request in, stall/HI-LO write port out)
module muldiv_seq #(
    parameter int MUL_CYCLES = 2
) (
    input logic         cpu_clk_50M,
    input logic         cpu_rst_n,
    muldiv_seq_if.slave bus
);
    localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3, OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    state_t      state, nxt;
    logic [5:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a, b, q, r, d, res_hi, res_lo;
    logic        accept, is_mul, is_div, is_mt, mul_last, div_last;
    logic [63:0] prod;
    logic [32:0] rem_sh;
    logic        fits;
    assign is_mul   = bus.op == OP_MULT || bus.op == OP_MULTU;
    assign is_div   = bus.op == OP_DIV || bus.op == OP_DIVU;
    assign is_mt    = bus.op == OP_MTHI || bus.op == OP_MTLO;
    assign accept   = cpu_rst_n && state == IDLE && bus.op_valid && !bus.flush;
    assign mul_last = cnt == 6'(MUL_CYCLES - 1);
    assign div_last = cnt == 6'd31;
    // sign-extend to 64 bits only for MULT so the low 64 bits are the right product either way
    assign prod     = {{32{op_q == OP_MULT && a[31]}}, a} * {{32{op_q == OP_MULT && b[31]}}, b};
    // restoring step: shift next dividend bit into the partial remainder and try subtracting the divisor
    assign rem_sh   = {r, q[31]};
    assign fits     = rem_sh >= {1'b0, d};
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !accept ? IDLE : is_mul ? MUL : is_div ? DIV : is_mt ? DONE : IDLE;
            MUL:     nxt = bus.flush ? IDLE : mul_last ? DONE : MUL;
            DIV:     nxt = bus.flush ? IDLE : div_last ? FIX : DIV;
            FIX:     nxt = bus.flush ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        bus.busy    = state != IDLE;
        bus.hilowe  = state == DONE;
        bus.stall_o = (accept && (is_mul || is_div)) || state == MUL || state == DIV || state == FIX;
        bus.hi_o    = !bus.hilowe ? 32'd0 : op_q == OP_MTLO ? bus.hi_cur : res_hi;
        bus.lo_o    = !bus.hilowe ? 32'd0 : op_q == OP_MTHI ? bus.lo_cur : res_lo;
    end
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            cnt    <= '0;
            op_q   <= '0;
            a      <= '0;
            b      <= '0;
            q      <= '0;
            r      <= '0;
            d      <= '0;
            res_hi <= '0;
            res_lo <= '0;
        end else begin
            if (accept) begin
                cnt  <= '0;
                op_q <= bus.op;
                a    <= bus.rs_i;
                b    <= bus.rt_i;
                q    <= bus.op == OP_DIV && bus.rs_i[31] ? -bus.rs_i : bus.rs_i;
                d    <= bus.op == OP_DIV && bus.rt_i[31] ? -bus.rt_i : bus.rt_i;
                r    <= '0;
                if (is_mt) begin
                    res_hi <= bus.rs_i;
                    res_lo <= bus.rs_i;
                end
            end
            if (state == MUL || state == DIV)
                cnt <= cnt + 6'd1;
            if (state == MUL && mul_last)
                {res_hi, res_lo} <= prod;
            if (state == DIV) begin
                r <= fits ? rem_sh[31:0] - d : rem_sh[31:0];
                q <= {q[30:0], fits};
            end
            // a zero divisor leaves |rs| as remainder, so only the quotient needs forcing
            if (state == FIX) begin
                res_lo <= b == 32'd0 ? '1 : op_q == OP_DIV && (a[31] ^ b[31]) ? -q : q;
                res_hi <= op_q == OP_DIV && a[31] ? -r : r;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq
module tb_muldiv_seq;
    localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3, DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6, RSV = 3'd7;
    logic cpu_clk_50M = 1'b0;
    logic cpu_rst_n   = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    muldiv_seq_if bus();
    muldiv_seq #(.MUL_CYCLES(2)) dut (
        .cpu_clk_50M(cpu_clk_50M),
        .cpu_rst_n  (cpu_rst_n),
        .bus        (bus)
    );
    always #5 cpu_clk_50M = ~cpu_clk_50M;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge cpu_clk_50M);
        #1;
    endtask
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt,
                          input int lat, input logic stl, input logic [31:0] eh, input logic [31:0] el);
        int early = 0;
        int sbad  = 0;
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.rs_i     = rs;
        bus.rt_i     = rt;
        bus.flush    = 1'b0;
        #1;
        check({tag, ".stall_T"}, 32'(bus.stall_o), 32'(stl));
        for (int k = 1; k <= lat; k++) begin
            tick();
            if (k == 1) begin
                bus.op_valid = 1'b0;
                bus.rs_i     = $urandom;
                bus.rt_i     = $urandom;
            end
            if (k < lat) begin
                if (bus.hilowe) early++;
                if (bus.stall_o !== stl) sbad++;
            end
        end
        check({tag, ".early_we"}, 32'(early), 32'd0);
        check({tag, ".stall_run"}, 32'(sbad), 32'd0);
        check({tag, ".we"}, 32'(bus.hilowe), 32'd1);
        check({tag, ".hi"}, bus.hi_o, eh);
        check({tag, ".lo"}, bus.lo_o, el);
        check({tag, ".stall_done"}, 32'(bus.stall_o), 32'd0);
        tick();
        check({tag, ".we_once"}, 32'(bus.hilowe), 32'd0);
        check({tag, ".idle"}, 32'(bus.busy), 32'd0);
        check({tag, ".hi_zero"}, bus.hi_o, 32'd0);
    endtask
    initial begin
        bus.op_valid = 1'b1;
        bus.op       = DIV;
        bus.rs_i     = 32'd5;
        bus.rt_i     = 32'd1;
        bus.hi_cur   = 32'd5;
        bus.lo_cur   = 32'd9;
        bus.flush    = 1'b0;
        tick();
        tick();
        check("rst.we", 32'(bus.hilowe), 32'd0);
        check("rst.hi", bus.hi_o, 32'd0);
        check("rst.lo", bus.lo_o, 32'd0);
        check("rst.stall", 32'(bus.stall_o), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        bus.op_valid = 1'b0;
        cpu_rst_n    = 1'b1;
        tick();
        run_op("mult",  MULT,  32'hFFFFFFFE, 32'd3,        3,  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", MULTU, 32'hFFFFFFFE, 32'd3,        3,  1'b1, 32'h00000002, 32'hFFFFFFFA);
        run_op("mult2", MULT,  32'd7,        32'hFFFFFFFB, 3,  1'b1, 32'hFFFFFFFF, 32'hFFFFFFDD);
        run_op("divu",  DIVU,  32'd100,      32'd7,        34, 1'b1, 32'd2,        32'd14);
        run_op("div",   DIV,   32'hFFFFFFF9, 32'd2,        34, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div2",  DIV,   32'd7,        32'hFFFFFFFE, 34, 1'b1, 32'd1,        32'hFFFFFFFD);
        run_op("div0",  DIV,   32'h12345678, 32'd0,        34, 1'b1, 32'h12345678, 32'hFFFFFFFF);
        run_op("divu0", DIVU,  32'hFFFFFFF0, 32'd0,        34, 1'b1, 32'hFFFFFFF0, 32'hFFFFFFFF);
        run_op("ovf",   DIV,   32'h80000000, 32'hFFFFFFFF, 34, 1'b1, 32'd0,        32'h80000000);
        run_op("divuo", DIVU,  32'h80000000, 32'hFFFFFFFF, 34, 1'b1, 32'h80000000, 32'd0);
        run_op("mtlo",  MTLO,  32'h0000ABCD, 32'd0,        1,  1'b0, 32'd5,        32'h0000ABCD);
        run_op("mthi",  MTHI,  32'h00001234, 32'd0,        1,  1'b0, 32'h00001234, 32'd9);
        bus.op_valid = 1'b1;
        bus.op       = RSV;
        #1;
        check("rsv.stall", 32'(bus.stall_o), 32'd0);
        tick();
        bus.op = NOP;
        check("rsv.busy", 32'(bus.busy), 32'd0);
        tick();
        check("nop.busy", 32'(bus.busy), 32'd0);
        bus.op    = MULT;
        bus.flush = 1'b1;
        #1;
        check("iflush.stall", 32'(bus.stall_o), 32'd0);
        tick();
        bus.op_valid = 1'b0;
        bus.flush    = 1'b0;
        check("iflush.busy", 32'(bus.busy), 32'd0);
        begin
            int pulses = 0;
            bus.op_valid = 1'b1;
            bus.op       = DIV;
            bus.rs_i     = 32'd1000;
            bus.rt_i     = 32'd3;
            for (int k = 1; k <= 10; k++) begin
                tick();
                bus.op_valid = 1'b0;
                if (bus.hilowe) pulses++;
            end
            bus.flush = 1'b1;
            #1;
            check("dflush.stall_T10", 32'(bus.stall_o), 32'd1);
            tick();
            bus.flush = 1'b0;
            if (bus.hilowe) pulses++;
            check("dflush.pulses", 32'(pulses), 32'd0);
            check("dflush.stall_T11", 32'(bus.stall_o), 32'd0);
            check("dflush.busy_T11", 32'(bus.busy), 32'd0);
        end
        run_op("after_flush", DIVU, 32'd100, 32'd7, 34, 1'b1, 32'd2, 32'd14);
        bus.op_valid = 1'b1;
        bus.op       = MTHI;
        bus.rs_i     = 32'h0000BEEF;
        tick();
        bus.op_valid = 1'b0;
        bus.flush    = 1'b1;
        #1;
        check("doneflush.we", 32'(bus.hilowe), 32'd1);
        check("doneflush.hi", bus.hi_o, 32'h0000BEEF);
        tick();
        bus.flush = 1'b0;
        check("doneflush.idle", 32'(bus.busy), 32'd0);
        begin
            int pulses = 0;
            bus.op_valid = 1'b1;
            bus.op       = DIV;
            bus.rs_i     = 32'd1000;
            bus.rt_i     = 32'd3;
            for (int k = 1; k <= 20; k++) begin
                tick();
                bus.op_valid = 1'b0;
                if (bus.hilowe) pulses++;
            end
            cpu_rst_n = 1'b0;
            tick();
            cpu_rst_n = 1'b1;
            check("mrst.pulses", 32'(pulses), 32'd0);
            check("mrst.we", 32'(bus.hilowe), 32'd0);
            check("mrst.hi", bus.hi_o, 32'd0);
            check("mrst.lo", bus.lo_o, 32'd0);
            check("mrst.stall", 32'(bus.stall_o), 32'd0);
            check("mrst.busy", 32'(bus.busy), 32'd0);
        end
        run_op("after_rst", MTLO, 32'h0000ABCD, 32'd0, 1, 1'b0, 32'd5, 32'h0000ABCD);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
